// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   mem_size_e   : 4-bit memRWSize codes, also driven by the instruction decoder
//   lsu_state_e  : FSM state encoding, exported for debug visibility
//   size_bytes() : access width in bytes for a code, 0 for an unknown code
//   size_is_signed() : 1 when a load of this code sign-extends
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        MEM_BYTE_SIGNED       = 4'd0,
        MEM_HALFWORD_SIGNED   = 4'd1,
        MEM_WORD_SIGNED       = 4'd2,
        MEM_BYTE_UNSIGNED     = 4'd4,
        MEM_HALFWORD_UNSIGNED = 4'd5
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [3:0] code);
        case (code)
            MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED:         return 3'd1;
            MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: return 3'd2;
            MEM_WORD_SIGNED:                            return 3'd4;
            default:                                    return 3'd0;
        endcase
    endfunction

    // The word code counts as signed: a 32-bit load needs no extension,
    // and this keeps "store with an unsigned code" a simple test.
    function automatic logic size_is_signed(input logic [3:0] code);
        case (code)
            MEM_BYTE_SIGNED, MEM_HALFWORD_SIGNED, MEM_WORD_SIGNED: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the request/response and data-memory bus signals of the LSU.
//   slave  : the load_store_unit's view (takes requests, drives the memory bus)
//   master : the environment's view (execute stage plus data memory)
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds req_valid and all req_* fields
// stable until then, and req_ready never depends combinationally on req_valid.
// Memory beats: mem_req and all mem_* outputs stay stable until a rising edge
// with mem_ack high; mem_rdata is sampled on that same edge.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [3:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_fault;
    logic [31:0]       resp_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_fault, resp_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_fault, resp_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane steering for the LSU, shared by both bus beats.
//   offset, nbytes, is_signed : byte offset in word, access width, extension
//   wdata                     : right-aligned store data
//   lo, hi                    : first- and second-beat read words (hi=0 if one beat)
//   split                     : access crosses a word boundary
//   be0/be1, wdata0/wdata1    : lane enables and lane-aligned data per beat
//   rdata                     : realigned, extended load data
// Both beats come from one 64-bit view: shifting the access left by the
// offset puts beat 0 in the low word and the spill-over in the high word.
module load_store_unit_align (
    input  logic [1:0]  offset,
    input  logic [2:0]  nbytes,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);
    logic [3:0]  lane_mask;
    logic [7:0]  be_all;
    logic [63:0] wd_all;
    logic [31:0] rd_shift;
    logic [4:0]  bit_shift;

    always_comb begin
        bit_shift = {offset, 3'b000};
        case (nbytes)
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            3'd4:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase

        split  = ({2'b00, offset} + {1'b0, nbytes}) > 4'd4;
        be_all = {4'b0000, lane_mask} << offset;
        be0    = be_all[3:0];
        be1    = be_all[7:4];

        wd_all = {32'h0, wdata} << bit_shift;
        wdata0 = wd_all[31:0];
        wdata1 = wd_all[63:32];

        rd_shift = 32'({hi, lo} >> bit_shift);
        case (nbytes)
            3'd1:    rdata = {{24{is_signed & rd_shift[7]}},  rd_shift[7:0]};
            3'd2:    rdata = {{16{is_signed & rd_shift[15]}}, rd_shift[15:0]};
            default: rdata = rd_shift;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory.
//   clk, rst   : clock and asynchronous active-high reset
//   bus        : request/response and memory bus signals (slave view)
//   dbg_state  : current FSM state
// One access per accepted request; a word-crossing access becomes two beats
// (or a fault when ALLOW_MISALIGNED=0). Exactly one response per request.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus,
    output lsu_state_e         dbg_state
);
    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    lsu_state_e  state;
    logic        write_q;
    logic [3:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;

    logic [1:0]  cur_off;
    logic [3:0]  cur_size;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_nbytes;
    logic        cur_signed;
    logic [31:0] lo_in;
    logic [31:0] hi_in;
    logic        split;
    logic [3:0]  be0, be1;
    logic [31:0] wdata0, wdata1, rdata_ext;
    logic        bad_code;
    logic        fault_req;

    // In IDLE the steering looks at the live request so beat 0 can be
    // registered on the accepting edge; afterwards it uses the captured copy.
    // The read word arriving with the current ack feeds the extractor directly
    // so the response data is registered on that same edge.
    always_comb begin
        if (state == S_IDLE) begin
            cur_off   = bus.req_addr[1:0];
            cur_size  = bus.req_size;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_off   = off_q;
            cur_size  = size_q;
            cur_wdata = wdata_q;
        end
        cur_nbytes = size_bytes(cur_size);
        cur_signed = size_is_signed(cur_size);
        lo_in      = (state == S_BEAT0) ? bus.mem_rdata : lo_q;
        hi_in      = (state == S_BEAT1) ? bus.mem_rdata : 32'h0;
        bad_code   = (cur_nbytes == 3'd0) || (bus.req_write && !cur_signed);
        fault_req  = bad_code || (split && !ALLOW_MISALIGNED);
    end

    load_store_unit_align u_align (
        .offset    (cur_off),
        .nbytes    (cur_nbytes),
        .is_signed (cur_signed),
        .wdata     (cur_wdata),
        .lo        (lo_in),
        .hi        (hi_in),
        .split     (split),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rdata     (rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            write_q        <= 1'b0;
            size_q         <= 4'h0;
            off_q          <= 2'b00;
            wdata_q        <= 32'h0;
            lo_q           <= 32'h0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_fault <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= 4'h0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        write_q       <= bus.req_write;
                        size_q        <= bus.req_size;
                        off_q         <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata;
                        lo_q          <= 32'h0;
                        bus.req_ready <= 1'b0;
                        if (fault_req) begin
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end else begin
                            state         <= S_BEAT0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_write;
                            bus.mem_be    <= be0;
                            bus.mem_addr  <= bus.req_addr[ADDR_W-1:2];
                            bus.mem_wdata <= wdata0;
                        end
                    end
                end
                S_BEAT0: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        lo_q        <= bus.mem_rdata;
                        if (split) begin
                            // mem_req stays low for one cycle before beat 1.
                            state         <= S_BEAT1;
                            bus.mem_be    <= be1;
                            bus.mem_addr  <= bus.mem_addr + WORD_ONE;
                            bus.mem_wdata <= wdata1;
                        end else begin
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= write_q ? 32'h0 : rdata_ext;
                            bus.mem_we     <= 1'b0;
                            bus.mem_be     <= 4'h0;
                            bus.mem_wdata  <= 32'h0;
                        end
                    end
                end
                S_BEAT1: begin
                    // An ack during the gap cycle is not for this beat.
                    if (!bus.mem_req) begin
                        bus.mem_req <= 1'b1;
                    end else if (bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= write_q ? 32'h0 : rdata_ext;
                        bus.mem_we     <= 1'b0;
                        bus.mem_be     <= 4'h0;
                        bus.mem_wdata  <= 32'h0;
                    end
                end
                S_RESP: begin
                    state          <= S_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_fault <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  load_store_unit_if #(.ADDR_W(32)) ia();
  load_store_unit_if #(.ADDR_W(32)) ib();
  lsu_state_e dbg_a, dbg_b;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave), .dbg_state(dbg_a)
  );
  load_store_unit #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int errors  = 0;
  logic [32:0] exp_a_q[$];   // {fault, rdata}
  logic [32:0] exp_b_q[$];
  int          cyc_a_q[$];   // expected response cycle, -1 = not checked
  int          cyc_b_q[$];
  logic [67:0] exp_beat_q[$]; // {hold, we, be, addr, wdata} for dut_a
  logic [31:0] mem_m [logic [29:0]];
  int ack_delay = 0;
  bit b_bus_seen = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  function automatic logic [67:0] bt(input bit hold, input bit we, input logic [3:0] be,
                                     input logic [29:0] a, input logic [31:0] wd);
    return {hold, we, be, a, wd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- memory responder for dut_a ----------------
  initial begin
    logic [67:0] cur;
    logic [66:0] act;
    logic [31:0] w;
    bit in_beat;
    int dly;
    ia.mem_ack = 1'b0;
    ia.mem_rdata = 32'h0;
    in_beat = 1'b0;
    dly = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      act = {ia.mem_we, ia.mem_be, ia.mem_addr, ia.mem_wdata};
      if (rst) begin
        ia.mem_ack = 1'b0;
        in_beat = 1'b0;
      end else if (ia.mem_ack) begin
        ia.mem_ack = 1'b0;
        vectors++;
        if (ia.mem_req !== 1'b0) begin
          errors++;
          $display("FAIL bus_gap: mem_req got %b required 0", ia.mem_req);
        end
      end else if (ia.mem_req === 1'b1) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          dly = ack_delay;
          vectors++;
          if (exp_beat_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got we/be/addr/wdata %h", act);
            cur = {1'b0, act};
          end else begin
            cur = exp_beat_q.pop_front();
            if (act !== cur[66:0]) begin
              errors++;
              $display("FAIL beat: got we=%b be=%b addr=%h wdata=%h required we=%b be=%b addr=%h wdata=%h",
                       act[66], act[65:62], act[61:32], act[31:0],
                       cur[66], cur[65:62], cur[61:32], cur[31:0]);
            end
          end
        end else begin
          vectors++;
          if (act !== cur[66:0]) begin
            errors++;
            $display("FAIL beat_stable: got %h required %h", act, cur[66:0]);
          end
        end
        if (!cur[67]) begin
          if (dly > 0) dly--;
          else begin
            w = mem_rd(ia.mem_addr);
            if (ia.mem_we) begin
              for (int i = 0; i < 4; i++)
                if (ia.mem_be[i]) w[8*i +: 8] = ia.mem_wdata[8*i +: 8];
              mem_m[ia.mem_addr] = w;
            end
            ia.mem_rdata = w;
            ia.mem_ack = 1'b1;
            in_beat = 1'b0;
          end
        end
      end
    end
  end

  // dut_b only ever sees faulting requests, so it must never touch the bus.
  initial begin
    ib.mem_ack = 1'b0;
    ib.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (ib.mem_req === 1'b1) b_bus_seen = 1'b1;
    end
  end

  // ---------------- response monitors ----------------
  initial forever begin
    logic [32:0] e;
    int c;
    @(negedge clk);
    if (ia.resp_valid === 1'b1) begin
      vectors++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL resp_a_unexpected: got fault=%b rdata=%h", ia.resp_fault, ia.resp_rdata);
      end else begin
        e = exp_a_q.pop_front();
        c = cyc_a_q.pop_front();
        if ({ia.resp_fault, ia.resp_rdata} !== e) begin
          errors++;
          $display("FAIL resp_a: got fault=%b rdata=%h required fault=%b rdata=%h",
                   ia.resp_fault, ia.resp_rdata, e[32], e[31:0]);
        end
        if (c >= 0) begin
          vectors++;
          if (cyc != c) begin
            errors++;
            $display("FAIL lat_a: got cycle %0d required %0d", cyc, c);
          end
        end
      end
    end
  end

  initial forever begin
    logic [32:0] e;
    int c;
    @(negedge clk);
    if (ib.resp_valid === 1'b1) begin
      vectors++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL resp_b_unexpected: got fault=%b rdata=%h", ib.resp_fault, ib.resp_rdata);
      end else begin
        e = exp_b_q.pop_front();
        c = cyc_b_q.pop_front();
        if ({ib.resp_fault, ib.resp_rdata} !== e) begin
          errors++;
          $display("FAIL resp_b: got fault=%b rdata=%h required fault=%b rdata=%h",
                   ib.resp_fault, ib.resp_rdata, e[32], e[31:0]);
        end
        if (c >= 0) begin
          vectors++;
          if (cyc != c) begin
            errors++;
            $display("FAIL lat_b: got cycle %0d required %0d", cyc, c);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // lat = edges from the accepting edge to the edge that raises resp_valid.
  task automatic issue(input bit sel, input bit wr, input logic [3:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit exp_resp, input bit f, input logic [31:0] rd, input int lat);
    int t;
    int acc;
    logic rdy;
    t = 0;
    if (exp_resp) begin
      if (sel) exp_b_q.push_back({f, rd});
      else     exp_a_q.push_back({f, rd});
    end
    @(negedge clk);
    if (sel) begin
      ib.req_valid = 1'b1; ib.req_write = wr; ib.req_size = sz; ib.req_addr = addr; ib.req_wdata = wd;
    end else begin
      ia.req_valid = 1'b1; ia.req_write = wr; ia.req_size = sz; ia.req_addr = addr; ia.req_wdata = wd;
    end
    rdy = sel ? ib.req_ready : ia.req_ready;
    while (rdy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
      rdy = sel ? ib.req_ready : ia.req_ready;
    end
    vectors++;
    if (t >= 100) begin
      errors++;
      $display("FAIL req_accept: got req_ready=0 for %0d cycles required 1", t);
    end
    acc = cyc + 1;
    if (exp_resp) begin
      if (sel) cyc_b_q.push_back((lat >= 0) ? acc + lat : -1);
      else     cyc_a_q.push_back((lat >= 0) ? acc + lat : -1);
    end
    @(posedge clk);
    #1;
    ia.req_valid = 1'b0;
    ib.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0 || exp_beat_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 200) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending required 0/0/0",
               exp_a_q.size(), exp_b_q.size(), exp_beat_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got simulation still running required finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t;
    ia.req_valid = 1'b0; ia.req_write = 1'b0; ia.req_size = 4'h0; ia.req_addr = 32'h0; ia.req_wdata = 32'h0;
    ib.req_valid = 1'b0; ib.req_write = 1'b0; ib.req_size = 4'h0; ib.req_addr = 32'h0; ib.req_wdata = 32'h0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", {31'h0, ia.req_ready}, 32'h1);
    chk("rst_mem_req_a", {31'h0, ia.mem_req}, 32'h0);
    chk("rst_resp_valid_a", {31'h0, ia.resp_valid}, 32'h0);
    chk("rst_mem_be_a", {28'h0, ia.mem_be}, 32'h0);
    chk("rst_state_a", {30'h0, dbg_a}, {30'h0, S_IDLE});
    chk("rst_ready_b", {31'h0, ib.req_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", {31'h0, ia.req_ready}, 32'h1);

    // aligned lw
    mem_m[30'h40] = 32'hDEADBEEF;
    exp_beat_q.push_back(bt(0, 0, 4'hF, 30'h40, 32'h0));
    issue(0, 0, MEM_WORD_SIGNED, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF, 1);
    wait_done();

    // lb / lbu in lane 3
    mem_m[30'h40] = 32'h80112233;
    exp_beat_q.push_back(bt(0, 0, 4'h8, 30'h40, 32'h0));
    issue(0, 0, MEM_BYTE_SIGNED, 32'h103, 32'h0, 1, 0, 32'hFFFFFF80, 1);
    wait_done();
    exp_beat_q.push_back(bt(0, 0, 4'h8, 30'h40, 32'h0));
    issue(0, 0, MEM_BYTE_UNSIGNED, 32'h103, 32'h0, 1, 0, 32'h00000080, 1);
    wait_done();

    // lh / lhu inside one word at offset 1
    mem_m[30'h5] = 32'hA1B2C3D4;
    exp_beat_q.push_back(bt(0, 0, 4'h6, 30'h5, 32'h0));
    issue(0, 0, MEM_HALFWORD_UNSIGNED, 32'h15, 32'h0, 1, 0, 32'h0000B2C3, 1);
    wait_done();
    exp_beat_q.push_back(bt(0, 0, 4'h6, 30'h5, 32'h0));
    issue(0, 0, MEM_HALFWORD_SIGNED, 32'h15, 32'h0, 1, 0, 32'hFFFFB2C3, 1);
    wait_done();

    // split sh across words 0/1
    exp_beat_q.push_back(bt(0, 1, 4'h8, 30'h0, 32'hCD000000));
    exp_beat_q.push_back(bt(0, 1, 4'h1, 30'h1, 32'h000000AB));
    issue(0, 1, MEM_HALFWORD_SIGNED, 32'h3, 32'h0000ABCD, 1, 0, 32'h0, 3);
    wait_done();

    // split sw at offset 1
    exp_beat_q.push_back(bt(0, 1, 4'hE, 30'h1, 32'h22334400));
    exp_beat_q.push_back(bt(0, 1, 4'h1, 30'h2, 32'h00000011));
    issue(0, 1, MEM_WORD_SIGNED, 32'h5, 32'h11223344, 1, 0, 32'h0, 3);
    wait_done();

    // split lw wrapping the word address
    mem_m[30'h3FFFFFFF] = 32'h11223344;
    mem_m[30'h0]        = 32'h55667788;
    exp_beat_q.push_back(bt(0, 0, 4'hC, 30'h3FFFFFFF, 32'h0));
    exp_beat_q.push_back(bt(0, 0, 4'h3, 30'h0, 32'h0));
    issue(0, 0, MEM_WORD_SIGNED, 32'hFFFFFFFE, 32'h0, 1, 0, 32'h77881122, 3);
    wait_done();

    // slow memory: bus must hold steady while waiting
    ack_delay = 2;
    mem_m[30'h80] = 32'hCAFEF00D;
    exp_beat_q.push_back(bt(0, 0, 4'hF, 30'h80, 32'h0));
    issue(0, 0, MEM_WORD_SIGNED, 32'h200, 32'h0, 1, 0, 32'hCAFEF00D, -1);
    wait_done();
    ack_delay = 0;

    // bad codes on dut_a: store with unsigned code, undefined code
    issue(0, 1, MEM_BYTE_UNSIGNED, 32'h10, 32'h55, 1, 1, 32'h0, 0);
    wait_done();
    issue(0, 0, 4'd7, 32'h20, 32'h0, 1, 1, 32'h0, 0);
    wait_done();

    // dut_b: word-crossing accesses and bad code fault without bus activity
    issue(1, 0, MEM_HALFWORD_SIGNED, 32'h3, 32'h0, 1, 1, 32'h0, 0);
    wait_done();
    issue(1, 0, MEM_WORD_SIGNED, 32'h2, 32'h0, 1, 1, 32'h0, 0);
    wait_done();
    issue(1, 0, MEM_HALFWORD_UNSIGNED, 32'h7, 32'h0, 1, 1, 32'h0, 0);
    wait_done();
    issue(1, 0, 4'd7, 32'h8, 32'h0, 1, 1, 32'h0, 0);
    wait_done();

    // reset while beat 1 is pending: no response may appear
    exp_beat_q.push_back(bt(0, 0, 4'hC, 30'h1, 32'h0));
    exp_beat_q.push_back(bt(1, 0, 4'h3, 30'h2, 32'h0));
    issue(0, 0, MEM_WORD_SIGNED, 32'h6, 32'h0, 0, 0, 32'h0, -1);
    t = 0;
    while (!(dbg_a == S_BEAT1 && ia.mem_req === 1'b1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 50) begin
      errors++;
      $display("FAIL reach_beat1: got state %0d required %0d", dbg_a, S_BEAT1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'h0, ia.mem_req}, 32'h0);
    chk("arst_resp_valid", {31'h0, ia.resp_valid}, 32'h0);
    chk("arst_ready", {31'h0, ia.req_ready}, 32'h1);
    chk("arst_state", {30'h0, dbg_a}, {30'h0, S_IDLE});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_arst_ready", {31'h0, ia.req_ready}, 32'h1);
    chk("post_arst_mem_req", {31'h0, ia.mem_req}, 32'h0);

    // normal access after reset
    exp_beat_q.push_back(bt(0, 0, 4'hF, 30'h40, 32'h0));
    issue(0, 0, MEM_WORD_SIGNED, 32'h100, 32'h0, 1, 0, 32'h80112233, 1);
    wait_done();

    chk("b_no_bus", {31'h0, b_bus_seen}, 32'h0);
    chk("a_left_pending", exp_a_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
